// File: rtl/layer_4_maxpool2x2_pkg.sv
// ---------------------------------------------------------------------------
// layer_4_maxpool2x2_pkg
// Shared YOLOv3Tiny definitions used by the layer-4 max-pool block:
//   FP32_W          - width of an IEEE-754 single-precision word
//   FP32_SIGN_BIT   - sign bit position
//   FP32_EXP_HI/LO  - exponent field bounds
//   FP32_MAN_HI/LO  - mantissa field bounds
//   fp32_t          - raw fp32 word type
// ---------------------------------------------------------------------------
package layer_4_maxpool2x2_pkg;

    localparam int FP32_W        = 32;
    localparam int FP32_SIGN_BIT = 31;
    localparam int FP32_EXP_HI   = 30;
    localparam int FP32_EXP_LO   = 23;
    localparam int FP32_MAN_HI   = 22;
    localparam int FP32_MAN_LO   = 0;

    typedef logic [FP32_W-1:0] fp32_t;

endpackage

// File: rtl/layer_4_maxpool2x2_fp32_max.sv
// ---------------------------------------------------------------------------
// fp32_max
// Combinational maximum of two raw fp32 bit patterns.
//   a - first (earlier) operand, wins on identical patterns
//   b - second operand
//   y - selected operand
// Ordering works on the raw bits: the positive operand wins when signs
// differ (so +0 beats -0); with equal signs the {exponent,mantissa}
// magnitude decides, larger for positives and smaller for negatives.
// NaN and Inf are ordered by the same rule with no special casing.
// ---------------------------------------------------------------------------
module fp32_max
    import layer_4_maxpool2x2_pkg::*;
(
    input  fp32_t a,
    input  fp32_t b,
    output fp32_t y
);

    logic                   sign_a;
    logic                   sign_b;
    logic [FP32_EXP_HI:0]   mag_a;
    logic [FP32_EXP_HI:0]   mag_b;

    assign sign_a = a[FP32_SIGN_BIT];
    assign sign_b = b[FP32_SIGN_BIT];
    assign mag_a  = {a[FP32_EXP_HI:FP32_EXP_LO], a[FP32_MAN_HI:FP32_MAN_LO]};
    assign mag_b  = {b[FP32_EXP_HI:FP32_EXP_LO], b[FP32_MAN_HI:FP32_MAN_LO]};

    // b only replaces a when it is strictly greater, which keeps a on ties.
    always_comb begin
        y = a;
        if (sign_a != sign_b) begin
            y = sign_a ? b : a;
        end else if (!sign_a) begin
            if (mag_b > mag_a) y = b;
        end else begin
            if (mag_b < mag_a) y = b;
        end
    end

endmodule

// File: rtl/layer_4_maxpool2x2.sv
// ---------------------------------------------------------------------------
// layer_4_maxpool2x2
// Streaming 2x2 / stride-2 max-pool over an IMG_SIZE x IMG_SIZE fp32
// feature map delivered in raster order.
//   Clk       - clock, rising edge
//   Rst       - asynchronous active-high reset
//   data_in   - input pixel (fp32)
//   valid_in  - data_in carries a pixel this cycle
//   data_out  - pooled pixel (fp32), held while valid_out is low
//   valid_out - data_out is valid, one cycle after the bottom-right pixel
//               of each window
//   frame_end - pulses with the last valid_out of a frame
// Top-row horizontal maxima are parked in a half-width row buffer and
// merged with the bottom-row horizontal maxima on the following row.
// ---------------------------------------------------------------------------
module layer_4_maxpool2x2
    import layer_4_maxpool2x2_pkg::*;
#(
    parameter int DATA_WIDTH = FP32_W,
    parameter int IMG_SIZE   = 104
)
(
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  frame_end
);

    localparam int HALF = IMG_SIZE / 2;
    localparam int CW   = (IMG_SIZE > 2) ? $clog2(IMG_SIZE) : 1;
    localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;

    if ((IMG_SIZE % 2) != 0 || IMG_SIZE < 2) begin : g_bad_img_size
        $error("layer_4_maxpool2x2: IMG_SIZE must be even and >= 2");
    end

    if (DATA_WIDTH != FP32_W) begin : g_bad_data_width
        $error("layer_4_maxpool2x2: DATA_WIDTH must match the fp32 word width");
    end

    logic [CW-1:0]         col_p0;
    logic [CW-1:0]         row_p0;
    logic [DATA_WIDTH-1:0] cand_p0;
    logic                  col_odd;
    logic                  row_odd;
    logic                  col_last;
    logic                  row_last;
    logic [AW-1:0]         buf_addr;
    fp32_t                 hmax;
    fp32_t                 top_hmax;
    fp32_t                 vmax;

    logic [DATA_WIDTH-1:0] data_p1;
    logic                  vld_p1;
    logic                  fe_p1;

    logic [DATA_WIDTH-1:0] row_buf [HALF];

    assign col_odd  = col_p0[0];
    assign row_odd  = row_p0[0];
    assign col_last = (col_p0 == CW'(IMG_SIZE - 1));
    assign row_last = (row_p0 == CW'(IMG_SIZE - 1));
    assign buf_addr = AW'(col_p0 >> 1);

    // ---- stage 0: horizontal max of candidate and current pixel ----
    fp32_max u_hmax (
        .a (cand_p0),
        .b (data_in),
        .y (hmax)
    );

    // Even rows only write and odd rows only read, so a slot is never
    // read and written on the same cycle; every odd-row read sees the
    // value stored during the preceding even row.
    always_ff @(posedge Clk) begin
        if (valid_in && col_odd && !row_odd) begin
            row_buf[buf_addr] <= hmax;
        end
    end

    assign top_hmax = row_buf[buf_addr];

    fp32_max u_vmax (
        .a (top_hmax),
        .b (hmax),
        .y (vmax)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            col_p0  <= '0;
            row_p0  <= '0;
            cand_p0 <= '0;
            data_p1 <= '0;
            vld_p1  <= 1'b0;
            fe_p1   <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            fe_p1  <= 1'b0;
            if (valid_in) begin
                if (!col_odd) begin
                    cand_p0 <= data_in;
                end
                if (col_last) begin
                    col_p0 <= '0;
                    row_p0 <= row_last ? '0 : row_p0 + 1'b1;
                end else begin
                    col_p0 <= col_p0 + 1'b1;
                end
                // ---- stage 1: pooled result registered ----
                if (col_odd && row_odd) begin
                    data_p1 <= vmax;
                    vld_p1  <= 1'b1;
                    fe_p1   <= row_last && col_last;
                end
            end
        end
    end

    assign data_out  = data_p1;
    assign valid_out = vld_p1;
    assign frame_end = fe_p1;

endmodule

// File: tb/tb_layer_4_maxpool2x2.sv
module tb_layer_4_maxpool2x2;

    localparam int N_S = 4;
    localparam int N_L = 104;

    typedef struct {
        logic [31:0] d;
        logic        fe;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din_s, din_l, dout_s, dout_l;
    logic        vin_s, vin_l, vout_s, vout_l, fe_s, fe_l;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int out_cnt_l = 0;
    int fe_cnt_l = 0;

    exp_t        q_s[$];
    exp_t        q_l[$];
    logic [31:0] pix [N_L*N_L];
    logic [31:0] fx  [4];
    logic [31:0] last_s = '0;
    logic [31:0] last_l = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    layer_4_maxpool2x2 #(.DATA_WIDTH(32), .IMG_SIZE(N_S)) u_dut_s (
        .Clk(clk), .Rst(rst), .data_in(din_s), .valid_in(vin_s),
        .data_out(dout_s), .valid_out(vout_s), .frame_end(fe_s)
    );

    layer_4_maxpool2x2 #(.DATA_WIDTH(32), .IMG_SIZE(N_L)) u_dut_l (
        .Clk(clk), .Rst(rst), .data_in(din_l), .valid_in(vin_l),
        .data_out(dout_l), .valid_out(vout_l), .frame_end(fe_l)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%08h expected=%08h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Total-order key: positives above negatives, negative magnitudes inverted.
    function automatic logic [32:0] ord_key(input logic [31:0] x);
        return x[31] ? {1'b0, ~x} : {1'b1, x};
    endfunction

    function automatic logic [31:0] ref_max(input logic [31:0] a, input logic [31:0] b);
        return (ord_key(b) > ord_key(a)) ? b : a;
    endfunction

    function automatic logic [31:0] int_to_fp(input int v);
        int e = 0;
        logic [31:0] m;
        while ((v >> (e + 1)) != 0) e++;
        m = (32'(v) << (23 - e)) & 32'h007F_FFFF;
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    task automatic fill_ramp();
        for (int i = 0; i < N_S*N_S; i++) pix[i] = int_to_fp(i + 1);
        fx[0] = 32'h40C0_0000; fx[1] = 32'h4100_0000;
        fx[2] = 32'h4160_0000; fx[3] = 32'h4180_0000;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            vin_s = 1'b0;
            vin_l = 1'b0;
        end
    endtask

    task automatic drive_frame(input bit big, input int n, input int max_gap,
                               input int npix, input bit fixed);
        int k = 0;
        for (int i = 0; i < npix; i++) begin
            int r = i / n;
            int c = i % n;
            @(posedge clk); #1;
            if (big) begin din_l = pix[i]; vin_l = 1'b1; end
            else     begin din_s = pix[i]; vin_s = 1'b1; end
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                exp_t e;
                e.d   = fixed ? fx[k] : ref_max(ref_max(pix[i-n-1], pix[i-n]),
                                                ref_max(pix[i-1], pix[i]));
                e.fe  = (i == n*n - 1);
                e.due = cyc + 1;
                k++;
                if (big) q_l.push_back(e); else q_s.push_back(e);
            end
            if (max_gap > 0) begin
                int g = int'($urandom_range(max_gap, 1));
                for (int j = 0; j < g; j++) begin
                    @(posedge clk); #1;
                    if (big) begin vin_l = 1'b0; din_l = $urandom; end
                    else     begin vin_s = 1'b0; din_s = $urandom; end
                end
            end
        end
    endtask

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst) begin
            last_s = '0;
            last_l = '0;
        end else begin
            if (vout_s) begin
                if (q_s.size() == 0) check_val("s_spurious_vout", 32'(vout_s), 32'd0);
                else begin
                    e = q_s.pop_front();
                    check_val("s_data", dout_s, e.d);
                    check_val("s_frame_end", 32'(fe_s), 32'(e.fe));
                    check_val("s_latency", cyc, e.due);
                end
                last_s = dout_s;
            end else begin
                check_val("s_fe_idle", 32'(fe_s), 32'd0);
                check_val("s_hold", dout_s, last_s);
                if (q_s.size() > 0 && q_s[0].due < cyc) begin
                    check_val("s_missing_vout", 32'(vout_s), 32'd1);
                    void'(q_s.pop_front());
                end
            end
            if (vout_l) begin
                out_cnt_l++;
                if (fe_l) fe_cnt_l++;
                if (q_l.size() == 0) check_val("l_spurious_vout", 32'(vout_l), 32'd0);
                else begin
                    e = q_l.pop_front();
                    check_val("l_data", dout_l, e.d);
                    check_val("l_frame_end", 32'(fe_l), 32'(e.fe));
                    check_val("l_latency", cyc, e.due);
                end
                last_l = dout_l;
            end else begin
                check_val("l_fe_idle", 32'(fe_l), 32'd0);
                check_val("l_hold", dout_l, last_l);
                if (q_l.size() > 0 && q_l[0].due < cyc) begin
                    check_val("l_missing_vout", 32'(vout_l), 32'd1);
                    void'(q_l.pop_front());
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        vin_s = 1'b0; vin_l = 1'b0;
        din_s = '0;   din_l = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_dout_s", dout_s, 32'd0);
        check_val("rst_vout_s", 32'(vout_s), 32'd0);
        check_val("rst_fe_s", 32'(fe_s), 32'd0);
        check_val("rst_dout_l", dout_l, 32'd0);
        check_val("rst_vout_l", 32'(vout_l), 32'd0);
        check_val("rst_fe_l", 32'(fe_l), 32'd0);
        rst = 1'b0;

        // 1.0 .. 16.0 ramp, continuous valid
        fill_ramp();
        drive_frame(1'b0, N_S, 0, N_S*N_S, 1'b1);
        idle(4);

        // negative and signed-zero windows, plus Inf/NaN ordering
        pix[0]  = 32'hC040_0000; pix[1]  = 32'hBF80_0000;
        pix[2]  = 32'h8000_0000; pix[3]  = 32'h0000_0000;
        pix[4]  = 32'hC000_0000; pix[5]  = 32'hC080_0000;
        pix[6]  = 32'hBF80_0000; pix[7]  = 32'h8000_0000;
        pix[8]  = 32'h3F80_0000; pix[9]  = 32'h4000_0000;
        pix[10] = 32'h7F80_0000; pix[11] = 32'h7FC0_0000;
        pix[12] = 32'h4040_0000; pix[13] = 32'h4080_0000;
        pix[14] = 32'h40A0_0000; pix[15] = 32'hFFC0_0000;
        fx[0] = 32'hBF80_0000; fx[1] = 32'h0000_0000;
        fx[2] = 32'h4080_0000; fx[3] = 32'h7FC0_0000;
        drive_frame(1'b0, N_S, 0, N_S*N_S, 1'b1);
        idle(4);

        // ramp with random idle gaps between pixels
        fill_ramp();
        drive_frame(1'b0, N_S, 5, N_S*N_S, 1'b1);
        idle(4);

        // abort after pixel 7, then a fresh frame
        fill_ramp();
        drive_frame(1'b0, N_S, 0, 7, 1'b1);
        idle(3);
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        check_val("abort_rst_dout_s", dout_s, 32'd0);
        check_val("abort_rst_vout_s", 32'(vout_s), 32'd0);
        check_val("abort_queue_empty", 32'(q_s.size()), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive_frame(1'b0, N_S, 0, N_S*N_S, 1'b1);
        idle(4);

        // two back-to-back random frames on the full-size instance
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < N_L*N_L; i++) begin
                pix[i] = $urandom;
                if (i % 17 == 0) pix[i] = 32'h8000_0000;
                if (i % 23 == 0) pix[i] = 32'h0000_0000;
            end
            drive_frame(1'b1, N_L, 0, N_L*N_L, 1'b0);
        end
        idle(6);

        check_val("s_queue_drained", 32'(q_s.size()), 32'd0);
        check_val("l_queue_drained", 32'(q_l.size()), 32'd0);
        check_val("l_output_count", out_cnt_l, 32'd5408);
        check_val("l_frame_end_count", fe_cnt_l, 32'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/layer_4_maxpool2x2.md
LAYER_4_MAXPOOL2X2 -- requirements
Module: layer_4_maxpool2x2

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the IEEE-754 single-precision pixel width.
REQ-002 SHALL have parameter IMG_SIZE, default 104, the input feature-map width and height in pixels.
REQ-003 SHALL have port Clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port data_in  input  DATA_WIDTH  input pixel, fp32, raster order (row-major).
REQ-006 SHALL have port valid_in  input  1  data_in is a valid pixel this cycle.
REQ-007 SHALL have port data_out  output  DATA_WIDTH  pooled pixel, fp32.
REQ-008 SHALL have port valid_out  output  1  data_out is valid this cycle.
REQ-009 SHALL have port frame_end  output  1  one-cycle pulse coincident with the last valid_out of a frame.

Function
REQ-010 SHALL compute a 2x2 max-pool with stride 2 over one IMG_SIZE x IMG_SIZE feature map per frame, producing (IMG_SIZE/2)^2 outputs (2704 at default).
REQ-011 SHALL keep a column counter (0..IMG_SIZE-1) and a row counter (0..IMG_SIZE-1), both advancing only on valid_in. Column wraps to 0 and increments row. Row wraps to 0 after the last column of the last row, starting a new frame with no idle cycle.
REQ-012 SHALL hold all counters, registers and buffer contents unchanged on cycles with valid_in low. Gaps of any length SHALL NOT change results.
REQ-013 SHALL, on an even column, register data_in as the horizontal candidate. On an odd column, it SHALL form hmax = fmax(candidate, data_in).
REQ-014 SHALL, on an even row and odd column, write hmax into a row buffer of IMG_SIZE/2 entries at address col>>1.
REQ-015 SHALL, on an odd row and odd column, compute fmax(rowbuf[col>>1], hmax) and drive it on data_out with valid_out high exactly one cycle after that input (latency 1).
REQ-016 SHALL allow a row-buffer read and a write in the same cycle without hazard. Odd-row reads always return the entry written during the preceding even row.
REQ-017 SHALL define fmax on raw fp32 bit patterns as follows:
 - signs differ: the positive operand wins (+0 beats -0).
 - both positive: the larger {exponent,mantissa} wins.
 - both negative: the smaller {exponent,mantissa} wins.
 - equal patterns: the first (earlier) operand wins.
 - NaN/Inf get no special handling; they are ordered by the same rule.
REQ-018 SHALL hold data_out at its last value while valid_out is low.
REQ-019 SHALL assert frame_end together with valid_out for the output produced from row IMG_SIZE-1, column IMG_SIZE-1.
REQ-020 SHALL NOT support backpressure; valid_out is never stalled.
REQ-021 SHALL require IMG_SIZE even and >= 2. An odd value SHALL cause an elaboration-time error.

Reset
REQ-022 SHALL, while Rst is high, asynchronously force the counters and horizontal candidate to 0, data_out to 0, valid_out to 0 and frame_end to 0.
REQ-023 SHALL NOT reset row-buffer contents. Correctness SHALL NOT depend on them, since every entry is written before it is read.
REQ-024 SHALL, on Rst asserted mid-frame, discard the partial frame. The first valid_in after release is row 0, column 0, and no stale output is produced.

Structure
REQ-025 SHALL take DATA_WIDTH, the fp32 field positions (sign bit 31, exponent 30:23, mantissa 22:0) and the fp32 word typedef from the shared YOLOv3Tiny package.
REQ-026 SHALL instantiate a combinational sub-module fp32_max (inputs a, b, output y, rule REQ-017) twice: once for the horizontal stage and once for the vertical stage.
REQ-027 SHALL implement the row buffer as an inferable single-write, single-read memory of IMG_SIZE/2 words without reset.

Verification
REQ-028 SHALL pass this scenario with IMG_SIZE=4 and pixels 1.0..16.0 (0x3F800000..0x41800000) in raster order, continuous valid: exactly 4 outputs 6.0, 8.0, 14.0, 16.0, each 1 cycle after its odd-row/odd-column input, with frame_end on the 4th.
REQ-029 SHALL pass this scenario with a window {-3.0, -1.0, -2.0, -4.0}: output -1.0 (0xBF800000). With window {-0.0, +0.0, -1.0, -0.0}: output 0x00000000.
REQ-030 SHALL pass this scenario: the REQ-028 stream with valid_in deasserted for 1-5 random cycles between pixels gives identical outputs and order, and valid_out never asserts during a gap.
REQ-031 SHALL pass this scenario: Rst pulsed after pixel 7 of a frame, then a full fresh frame gives no output from the aborted frame and exactly 4 correct outputs from the new frame.
REQ-032 SHALL pass this scenario with IMG_SIZE=104: two back-to-back random frames give 2704 outputs each, matching a reference model bit-exactly, and frame_end asserts exactly twice.
